// File: rtl/stream_split2.sv
`default_nettype none
// ============================================================================
// Module   : stream_split2
// Brief    : Registered one-to-two valid/ready stream splitter with atomic
//            broadcast and a saturating drop counter.
// Revision : 1.0  initial release
// ============================================================================
module stream_split2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [1:0]    s_dest,
    output logic          a_valid,
    input  logic          a_ready,
    output logic [DW-1:0] a_data,
    output logic          b_valid,
    input  logic          b_ready,
    output logic [DW-1:0] b_data,
    output logic [7:0]    drop_cnt
);

    localparam logic [7:0] c_DROP_MAX = 8'hFF;

    logic          r_a_valid;
    logic [DW-1:0] r_a_data;
    logic          r_b_valid;
    logic [DW-1:0] r_b_data;
    logic [7:0]    r_drop_cnt;

    logic w_a_free;
    logic w_b_free;
    logic w_accept;
    logic w_load_a;
    logic w_load_b;
    logic w_drop;

    // A slot counts as free when it is empty or its beat leaves this cycle.
    assign w_a_free = ~r_a_valid | a_ready;
    assign w_b_free = ~r_b_valid | b_ready;

    // Both selected slots must be free, which makes a broadcast all-or-nothing.
    assign s_ready  = (~s_dest[0] | w_a_free) & (~s_dest[1] | w_b_free);
    assign w_accept = s_valid & s_ready;
    assign w_load_a = w_accept & s_dest[0];
    assign w_load_b = w_accept & s_dest[1];
    assign w_drop   = w_accept & (s_dest == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_valid  <= 1'b0;
            r_a_data   <= '0;
            r_b_valid  <= 1'b0;
            r_b_data   <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_load_a) begin
                r_a_valid <= 1'b1;
                r_a_data  <= s_data;
            end else if (a_ready) begin
                r_a_valid <= 1'b0;
            end

            if (w_load_b) begin
                r_b_valid <= 1'b1;
                r_b_data  <= s_data;
            end else if (b_ready) begin
                r_b_valid <= 1'b0;
            end

            if (w_drop && (r_drop_cnt != c_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign a_valid  = r_a_valid;
    assign a_data   = r_a_data;
    assign b_valid  = r_b_valid;
    assign b_data   = r_b_data;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stream_split2.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_split2
// Brief    : Directed and scoreboarded random bench for stream_split2.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_split2;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [1:0]    s_dest;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] b_data;
    logic [7:0]    drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    stream_split2 #(.DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_dest   (s_dest),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; s_valid = 1'b1; s_dest = 2'b11; s_data = 8'h77;
        a_ready = 1'b1; b_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({a_valid, b_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid: got %b%b want 00", a_valid, b_valid);
        end
        n_tests++;
        if ({a_data, b_data, drop_cnt} !== 24'h0) begin
            n_fail++; $display("FAIL reset_regs: a=%h b=%h drop=%0d want 0", a_data, b_data, drop_cnt);
        end
        @(negedge clk);
        n_tests++;
        if ({a_valid, b_valid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_no_beat: got %b%b want 00", a_valid, b_valid);
        end
    endtask

    task automatic test_stream_a();
        a_ready = 1'b1; b_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1; s_dest = 2'b01; s_data = 8'h10;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_tests++;
            if (s_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_a_ready[%0d]: got %b want 1", i, s_ready);
            end
            @(posedge clk); #1;
            n_tests++;
            if ({a_valid, a_data, b_valid} !== {1'b1, 8'(8'h10 + i), 1'b0}) begin
                n_fail++;
                $display("FAIL stream_a_beat[%0d]: a_valid=%b a_data=%h b_valid=%b want 1 %h 0",
                         i, a_valid, a_data, b_valid, 8'(8'h10 + i));
            end
            if (i < 15) s_data = 8'(8'h11 + i);
            else        s_valid = 1'b0;
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_a_drain: a_valid=%b want 0", a_valid);
        end
    endtask

    task automatic test_backpressure();
        a_ready = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_dest = 2'b01; s_data = 8'h55;
        @(posedge clk); #1;
        s_data = 8'h66;
        @(negedge clk);
        n_tests++;
        if ({a_valid, a_data, s_ready} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++; $display("FAIL bp_stall1: a_valid=%b a_data=%h s_ready=%b want 1 55 0", a_valid, a_data, s_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({a_valid, a_data, s_ready} !== {1'b1, 8'h55, 1'b0}) begin
            n_fail++; $display("FAIL bp_stall2: a_valid=%b a_data=%h s_ready=%b want 1 55 0", a_valid, a_data, s_ready);
        end
        a_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({a_data, s_ready} !== {8'h55, 1'b1}) begin
            n_fail++; $display("FAIL bp_release: a_data=%h s_ready=%b want 55 1", a_data, s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_tests++;
        if ({a_valid, a_data} !== {1'b1, 8'h66}) begin
            n_fail++; $display("FAIL bp_second: a_valid=%b a_data=%h want 1 66", a_valid, a_data);
        end
        @(posedge clk); #1;
        n_tests++;
        if (a_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_no_dup: a_valid=%b want 0", a_valid);
        end
    endtask

    task automatic test_broadcast();
        a_ready = 1'b1; b_ready = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_dest = 2'b10; s_data = 8'h3C;
        @(posedge clk); #1;
        s_dest = 2'b11; s_data = 8'hA5;
        @(negedge clk);
        n_tests++;
        if ({b_valid, b_data, s_ready} !== {1'b1, 8'h3C, 1'b0}) begin
            n_fail++; $display("FAIL bc_blocked: b_valid=%b b_data=%h s_ready=%b want 1 3c 0", b_valid, b_data, s_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({a_valid, b_data} !== {1'b0, 8'h3C}) begin
            n_fail++; $display("FAIL bc_atomic: a_valid=%b b_data=%h want 0 3c", a_valid, b_data);
        end
        b_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++; $display("FAIL bc_release: s_ready=%b want 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        n_tests++;
        if ({a_valid, a_data, b_valid, b_data} !== {1'b1, 8'hA5, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL bc_both: a=%b/%h b=%b/%h want 1/a5 1/a5", a_valid, a_data, b_valid, b_data);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({a_valid, b_valid} !== 2'b00) begin
            n_fail++; $display("FAIL bc_drain: a_valid=%b b_valid=%b want 0 0", a_valid, b_valid);
        end
    endtask

    task automatic test_drop();
        a_ready = 1'b1; b_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b1; s_dest = 2'b00; s_data = 8'hEE;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            n_tests++;
            if ({s_ready, a_valid, b_valid} !== 3'b100) begin
                n_fail++; $display("FAIL drop_flow[%0d]: s_ready=%b a_valid=%b b_valid=%b want 1 0 0", i, s_ready, a_valid, b_valid);
            end
            @(posedge clk); #1;
            if (i == 200 || i == 255) begin
                n_tests++;
                if (drop_cnt !== 8'(i)) begin
                    n_fail++; $display("FAIL drop_cnt_%0d: got %0d want %0d", i, drop_cnt, i);
                end
            end
        end
        s_valid = 1'b0;
        n_tests++;
        if (drop_cnt !== 8'd255) begin
            n_fail++; $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL drop_reset: got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] qa[$];
        logic [DW-1:0] qb[$];
        logic          stall_a = 1'b0;
        logic          stall_b = 1'b0;
        logic [DW-1:0] held_a = '0;
        logic [DW-1:0] held_b = '0;
        logic          exp_sr;
        for (int cyc = 0; cyc < 10040; cyc++) begin
            @(posedge clk); #1;
            if (stall_a && ({a_valid, a_data} !== {1'b1, held_a})) begin
                n_tests++; n_fail++;
                $display("FAIL rnd_hold_a[%0d]: a=%b/%h want 1/%h", cyc, a_valid, a_data, held_a);
            end else if (stall_a) n_tests++;
            if (stall_b && ({b_valid, b_data} !== {1'b1, held_b})) begin
                n_tests++; n_fail++;
                $display("FAIL rnd_hold_b[%0d]: b=%b/%h want 1/%h", cyc, b_valid, b_data, held_b);
            end else if (stall_b) n_tests++;
            if (cyc < 10000) begin
                s_valid = 1'($urandom_range(0, 1));
                s_dest  = 2'($urandom_range(0, 3));
                s_data  = 8'($urandom);
                a_ready = ($urandom_range(0, 3) != 0);
                b_ready = ($urandom_range(0, 3) != 0);
            end else begin
                s_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
            end
            @(negedge clk);
            exp_sr = (~s_dest[0] | ~a_valid | a_ready) & (~s_dest[1] | ~b_valid | b_ready);
            n_tests++;
            if (s_ready !== exp_sr) begin
                n_fail++; $display("FAIL rnd_s_ready[%0d]: got %b want %b", cyc, s_ready, exp_sr);
            end
            n_tests++;
            if ({a_valid, b_valid} !== {qa.size() != 0, qb.size() != 0}) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: a=%b b=%b want %b %b", cyc, a_valid, b_valid, qa.size() != 0, qb.size() != 0);
            end
            if (a_valid && a_ready && qa.size() != 0) begin
                n_tests++;
                if (a_data !== qa[0]) begin
                    n_fail++; $display("FAIL rnd_a_data[%0d]: got %h want %h", cyc, a_data, qa[0]);
                end
                void'(qa.pop_front());
            end
            if (b_valid && b_ready && qb.size() != 0) begin
                n_tests++;
                if (b_data !== qb[0]) begin
                    n_fail++; $display("FAIL rnd_b_data[%0d]: got %h want %h", cyc, b_data, qb[0]);
                end
                void'(qb.pop_front());
            end
            stall_a = a_valid & ~a_ready; held_a = a_data;
            stall_b = b_valid & ~b_ready; held_b = b_data;
            if (s_valid && exp_sr) begin
                if (s_dest[0]) qa.push_back(s_data);
                if (s_dest[1]) qb.push_back(s_data);
            end
        end
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++; $display("FAIL rnd_leftover: qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_dest = 2'b00;
        a_ready = 1'b0; b_ready = 1'b0;
        test_reset();
        test_stream_a();
        test_backpressure();
        test_broadcast();
        test_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
